// File: rtl/mult_ctrl_pkg.sv
// Shared types for the sequential shift-add multiplier control slice.
// Optional zero-bit add skipping is enabled by MULT_CTRL_SKIP_ADD_EN.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } mult_state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Bit-position counter for the multiplier control FSM.
// Saturates at WIDTH-1 and flags the last bit.
module mult_bit_counter
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    assign last = (cnt == LAST_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_seq_control.sv
// Control FSM for the sequential shift-add two's-complement multiplier.
// Define MULT_CTRL_SKIP_ADD_EN to fold zero-bit evaluations into the shift.
module mult_seq_control
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ClearA_LoadB,
    input  logic Execute,
    input  logic M,
    output logic Clr_Ld,
    output logic Clear,
    output logic Add,
    output logic Sub,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t      state;
    mult_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cnt_clr;
    logic             cnt_inc;

    mult_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk (Clk),
        .rst (Reset),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt),
        .last(last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Clr_Ld     = 1'b0;
        Clear      = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Shift_En   = 1'b0;
        Done       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        Busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                // Execute wins over a simultaneous load request
                Clr_Ld = ClearA_LoadB & ~Execute & ~Reset;
                if (Execute) begin
                    state_next = S_CLR;
                end
            end
            S_CLR: begin
                Clear      = 1'b1;
                cnt_clr    = 1'b1;
                state_next = S_EVAL;
            end
            S_EVAL: begin
`ifdef MULT_CTRL_SKIP_ADD_EN
                if (!M) begin
                    Shift_En = 1'b1;
                    if (last) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_inc    = 1'b1;
                        state_next = S_EVAL;
                    end
                end else begin
                    Add        = ~last;
                    Sub        = last;
                    state_next = S_SHIFT;
                end
`else
                // Sign bit of the multiplier carries negative weight
                Add        = M & ~last;
                Sub        = M & last;
                state_next = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                Shift_En = 1'b1;
                if (last) begin
                    state_next = S_DONE;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = S_EVAL;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (!Execute) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
